mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 69 ++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and shared-RAM signals of the memory arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           ram_addr, ram_wdata, ram_we
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto a shared RAM, one access per IDLE-ISSUE-RESP pass
module mem_arbiter #(
  parameter int DEPTH      = 128,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          port_q, port_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d, rdata;
  logic          if_gnt, d_gnt, gnt, issue, resp, fault;
  always_comb begin
    fault  = |addr_q[1:0] || {2'b00, addr_q[31:2]} >= 32'(DEPTH);
    issue  = !rst && state_q == ISSUE;
    resp   = !rst && state_q == RESP;
    if_gnt = !rst && state_q == IDLE && bus.if_req && (!bus.d_req || starve_q == SW'(STARVE_MAX));
    d_gnt  = !rst && state_q == IDLE && bus.d_req && !if_gnt;
    gnt    = if_gnt || d_gnt;
    state_d  = state_q == IDLE ? (gnt ? ISSUE : IDLE) : state_q == ISSUE ? RESP : IDLE;
    starve_d = if_gnt ? '0 :
               (bus.if_req && d_gnt && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    port_d  = gnt ? d_gnt : port_q;
    we_d    = gnt ? d_gnt && bus.d_we : we_q;
    addr_d  = gnt ? (d_gnt ? bus.d_addr : bus.if_addr) : addr_q;
    wdata_d = gnt ? (d_gnt ? bus.d_wdata : '0) : wdata_q;
    // RAM address/data buses hold their last driven value between accesses
    ram_addr_d  = rst ? '0 : issue ? {2'b00, addr_q[31:2]} : ram_addr_q;
    ram_wdata_d = rst ? '0 : issue ? wdata_q : ram_wdata_q;
    rdata = (!we_q && !fault) ? bus.ram_rdata : '0;
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.ram_addr  = ram_addr_d;
    bus.ram_wdata = ram_wdata_d;
    bus.ram_we    = issue && we_q && !fault;
    bus.if_rvalid = resp && !port_q;
    bus.d_rvalid  = resp && port_q;
    bus.if_err    = resp && !port_q && fault;
    bus.d_err     = resp && port_q && fault;
    bus.if_rdata  = (resp && !port_q) ? rdata : '0;
    bus.d_rdata   = (resp && port_q) ? rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end
endmodule
